// File: rtl/can_tx_serializer.sv
// CAN transmit bit engine: byte stream in, stuffed serial bits plus CRC-15 out.
// One-byte holding buffer feeds an MSB-first shifter paced by a prescaler.
module can_tx_serializer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [14:0] CRC_POLY   = 15'h4599
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [14:0]           crc,
  output logic                  crc_valid,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC
  } state_t;

  localparam logic [PRESCALE_W-1:0] ONE = 1;

  state_t                  state;
  state_t                  state_n;

  logic                    buf_full;
  logic [7:0]              buf_data;
  logic                    buf_last;

  logic [7:0]              sh;
  logic                    sh_last;
  logic [2:0]              rem;
  logic [3:0]              crem;
  logic [14:0]             crc_r;

  logic [PRESCALE_W-1:0]   cnt;
  logic [PRESCALE_W-1:0]   pre_l;
  logic                    lvl;
  logic [2:0]              run;

  logic                    tx_r;
  logic [14:0]             crc_q;
  logic                    crc_valid_r;
  logic                    err_r;

  logic                    tick;
  logic                    emit;
  logic                    nbit;
  logic                    pay;
  logic                    stuff;
  logic                    load;
  logic                    to_crc;
  logic                    fin;
  logic                    abort;
  logic                    accept;

  function automatic logic [14:0] crc_step(
    input logic [14:0] c,
    input logic        b
  );
    return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'd0);
  endfunction

  assign tick   = (cnt == '0);
  assign accept = s_valid && !buf_full;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Stuff bits take priority; end-of-byte and end-of-CRC decisions wait for them.
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    nbit    = 1'b1;
    pay     = 1'b0;
    stuff   = 1'b0;
    load    = 1'b0;
    to_crc  = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (buf_full) begin
          load    = 1'b1;
          emit    = 1'b1;
          pay     = 1'b1;
          nbit    = buf_data[7];
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (run == 3'd5) begin
            stuff = 1'b1;
            emit  = 1'b1;
            nbit  = ~lvl;
          end else if (rem != 3'd0) begin
            emit = 1'b1;
            pay  = 1'b1;
            nbit = sh[7];
          end else if (sh_last) begin
            to_crc  = 1'b1;
            emit    = 1'b1;
            nbit    = crc_r[14];
            state_n = S_CRC;
          end else if (buf_full) begin
            load = 1'b1;
            emit = 1'b1;
            pay  = 1'b1;
            nbit = buf_data[7];
          end else begin
            abort   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_CRC: begin
        if (tick) begin
          if (run == 3'd5) begin
            stuff = 1'b1;
            emit  = 1'b1;
            nbit  = ~lvl;
          end else if (crem != 4'd0) begin
            emit = 1'b1;
            nbit = crc_r[crem - 4'd1];
          end else begin
            fin     = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full    <= 1'b0;
      buf_data    <= '0;
      buf_last    <= 1'b0;
      sh          <= '0;
      sh_last     <= 1'b0;
      rem         <= '0;
      crem        <= '0;
      crc_r       <= '0;
      cnt         <= '0;
      pre_l       <= '0;
      lvl         <= 1'b1;
      run         <= '0;
      tx_r        <= 1'b1;
      crc_q       <= '0;
      crc_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (load) buf_full <= 1'b0;
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= s_data;
        buf_last <= s_last;
      end

      if (load) begin
        sh      <= {buf_data[6:0], 1'b0};
        sh_last <= buf_last;
        rem     <= 3'd7;
      end else if (emit && pay) begin
        sh  <= {sh[6:0], 1'b0};
        rem <= rem - 3'd1;
      end

      if (state == S_IDLE && load)
        crc_r <= crc_step(15'd0, nbit);
      else if (emit && pay)
        crc_r <= crc_step(crc_r, nbit);

      if (to_crc)
        crem <= 4'd14;
      else if (state == S_CRC && emit && !stuff)
        crem <= crem - 4'd1;

      if (state == S_IDLE) begin
        if (load) begin
          cnt   <= prescale;
          pre_l <= prescale;
        end
      end else if (emit) begin
        cnt <= pre_l;
      end else if (!tick) begin
        cnt <= cnt - ONE;
      end

      // A new frame restarts the run at its first bit.
      if (state == S_IDLE && load) begin
        lvl <= nbit;
        run <= 3'd1;
      end else if (emit) begin
        lvl <= nbit;
        run <= (nbit != lvl) ? 3'd1 : run + 3'd1;
      end

      if (emit)              tx_r <= nbit;
      else if (abort || fin) tx_r <= 1'b1;

      if (fin) crc_q <= crc_r;
      crc_valid_r <= fin;
      err_r       <= abort;
    end
  end

  always_comb begin
    s_ready   = !buf_full;
    busy      = (state != S_IDLE);
    tx        = tx_r;
    crc       = crc_q;
    crc_valid = crc_valid_r;
    err       = err_r;
  end

endmodule
